// File: rtl/sdram_wb_prefetch_bridge.sv
// Wishbone-to-SDRAM-controller bridge with a small linear read-prefetch buffer.
// Read misses refill the buffer from the missed word upward; writes invalidate it.
module sdram_wb_prefetch_bridge #(
  parameter logic [7:0] BASE_ADDR = 8'h38,
  parameter int         PF_DEPTH  = 4,
  parameter int         ADDR_W    = 23
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_rw,
  output logic [31:0]       ctrl_wdata,
  output logic [3:0]        ctrl_mask,
  output logic              ctrl_in_valid,
  input  logic              ctrl_busy,
  input  logic [31:0]       ctrl_rdata,
  input  logic              ctrl_out_valid
);
  localparam int IW = $clog2(PF_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, PF_REQ, PF_WAIT, WRITE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pf_base_q;
  logic [31:0]         buf_q [PF_DEPTH];
  logic [PF_DEPTH-1:0] vld_q;
  logic [IW-1:0]       idx_q;
  logic                abort_q;
  logic                ack_q;
  logic [31:0]         dat_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [31:0]         wdata_q;
  logic [3:0]          mask_q;
  logic                in_valid_q;

  logic              req;
  logic              hit;
  logic [ADDR_W-1:0] off;
  logic [IW-1:0]     hit_idx;
  logic [IW:0]       pf_nxt_idx;
  logic [ADDR_W:0]   pf_nxt_addr;
  logic              pf_more;
  logic              unused_adr;

  assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR) & ~ack_q;
  assign off     = wbs_adr_i[ADDR_W-1:0] - pf_base_q;
  assign hit_idx = off[IW+1:2];
  assign hit     = (off < ADDR_W'(4 * PF_DEPTH)) && vld_q[hit_idx];

  // Next prefetch slot; the extra address bit flags running past the top of SDRAM.
  assign pf_nxt_idx  = {1'b0, idx_q} + (IW+1)'(1);
  assign pf_nxt_addr = {1'b0, pf_base_q} + (ADDR_W+1)'({pf_nxt_idx, 2'b00});
  assign pf_more     = (pf_nxt_idx < (IW+1)'(PF_DEPTH)) && !pf_nxt_addr[ADDR_W];

  assign unused_adr = ^wbs_adr_i[23:ADDR_W];

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      idx_q      <= '0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      mask_q     <= '0;
      in_valid_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (wbs_we_i) begin
              vld_q      <= '0;
              addr_q     <= wbs_adr_i[ADDR_W-1:0];
              rw_q       <= 1'b1;
              wdata_q    <= wbs_dat_i;
              mask_q     <= wbs_sel_i;
              in_valid_q <= 1'b1;
              state_q    <= WRITE;
            end else if (hit) begin
              ack_q <= 1'b1;
              dat_q <= buf_q[hit_idx];
            end else begin
              vld_q      <= '0;
              pf_base_q  <= {wbs_adr_i[ADDR_W-1:2], 2'b00};
              addr_q     <= {wbs_adr_i[ADDR_W-1:2], 2'b00};
              rw_q       <= 1'b0;
              mask_q     <= 4'h0;
              in_valid_q <= 1'b1;
              idx_q      <= '0;
              abort_q    <= 1'b0;
              state_q    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!wbs_cyc_i) abort_q <= 1'b1;
          if (!ctrl_busy) begin
            in_valid_q <= 1'b0;
            state_q    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!wbs_cyc_i) abort_q <= 1'b1;
          if (ctrl_out_valid) begin
            buf_q[0] <= ctrl_rdata;
            vld_q[0] <= 1'b1;
            // An abandoned cycle still fills the buffer but must not be acked.
            if (!abort_q && wbs_cyc_i) begin
              ack_q <= 1'b1;
              dat_q <= ctrl_rdata;
            end
            if (pf_more) begin
              addr_q     <= pf_nxt_addr[ADDR_W-1:0];
              in_valid_q <= 1'b1;
              idx_q      <= pf_nxt_idx[IW-1:0];
              state_q    <= PF_REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        PF_REQ, PF_WAIT: begin
          if (req && !wbs_we_i && hit) begin
            ack_q <= 1'b1;
            dat_q <= buf_q[hit_idx];
          end
          if (state_q == PF_REQ) begin
            if (!ctrl_busy) begin
              in_valid_q <= 1'b0;
              state_q    <= PF_WAIT;
            end
          end else if (ctrl_out_valid) begin
            buf_q[idx_q] <= ctrl_rdata;
            vld_q[idx_q] <= 1'b1;
            if (pf_more) begin
              addr_q     <= pf_nxt_addr[ADDR_W-1:0];
              in_valid_q <= 1'b1;
              idx_q      <= pf_nxt_idx[IW-1:0];
              state_q    <= PF_REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WRITE: begin
          if (!ctrl_busy) begin
            in_valid_q <= 1'b0;
            ack_q      <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign ctrl_addr     = addr_q;
  assign ctrl_rw       = rw_q;
  assign ctrl_wdata    = wdata_q;
  assign ctrl_mask     = mask_q;
  assign ctrl_in_valid = in_valid_q;

endmodule
